// File: rtl/exe_writeback_pkg.sv
// Shared constants for the execute writeback stage.
// Also provides the scoreboard id width fallback when the shared defines are absent.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package exe_writeback_pkg;
  localparam int RD_W  = 5;
  localparam int VAL_W = 64;

  // Requester slots on the MDU/LSU arbiter.
  localparam int MDU_IDX = 0;
  localparam int LSU_IDX = 1;

  // x0 still completes in the scoreboard but never writes the register file.
  function automatic logic rf_write_en(input logic valid, input logic [RD_W-1:0] rd);
    return valid & (rd != '0);
  endfunction
endpackage

// File: rtl/exe_writeback_if.sv
// Execute-unit results in, single writeback port out.
// The master side is the set of execute units plus the writeback consumers.
interface exe_writeback_if
  import exe_writeback_pkg::*;
#(
  parameter int SID_W = `SCOREBOARD_SIZE_WIDTH,
  parameter int CNT_W = 32
);
  logic             flush_i;
  logic             alu_valid_i;
  logic [SID_W-1:0] alu_sid_i;
  logic [RD_W-1:0]  alu_rd_i;
  logic [VAL_W-1:0] alu_value_i;
  logic             mdu_valid_i;
  logic             mdu_ready_o;
  logic [SID_W-1:0] mdu_sid_i;
  logic [RD_W-1:0]  mdu_rd_i;
  logic [VAL_W-1:0] mdu_value_i;
  logic             lsu_valid_i;
  logic             lsu_ready_o;
  logic [SID_W-1:0] lsu_sid_i;
  logic [RD_W-1:0]  lsu_rd_i;
  logic [VAL_W-1:0] lsu_value_i;
  logic             wb_valid_o;
  logic [SID_W-1:0] wb_sid_o;
  logic [RD_W-1:0]  wb_rd_o;
  logic [VAL_W-1:0] wb_value_o;
  logic             wb_rf_we_o;
  logic [CNT_W-1:0] wb_conflict_cnt_o;

  modport slave (
    input  flush_i,
    input  alu_valid_i, alu_sid_i, alu_rd_i, alu_value_i,
    input  mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
    output mdu_ready_o,
    input  lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
    output lsu_ready_o,
    output wb_valid_o, wb_sid_o, wb_rd_o, wb_value_o, wb_rf_we_o, wb_conflict_cnt_o
  );

  modport master (
    output flush_i,
    output alu_valid_i, alu_sid_i, alu_rd_i, alu_value_i,
    output mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
    input  mdu_ready_o,
    output lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
    input  lsu_ready_o,
    input  wb_valid_o, wb_sid_o, wb_rd_o, wb_value_o, wb_rf_we_o, wb_conflict_cnt_o
  );
endinterface

// File: rtl/exe_writeback_rr_arb2.sv
// Two-requester round-robin arbiter; rr=0 prefers req[0], rr=1 prefers req[1].
// Ready per slot is independent of that slot's own request.
module wb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt,
  output logic [1:0] rdy
);
  logic r_rr;

  assign rdy[0] = ~block & (~req[1] | ~r_rr);
  assign rdy[1] = ~block & (~req[0] |  r_rr);
  assign gnt    = req & rdy;

  // Pointer moves to the other requester only after a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (gnt[0]) begin
      r_rr <= 1'b1;
    end else if (gnt[1]) begin
      r_rr <= 1'b0;
    end
  end
endmodule

// File: rtl/exe_writeback.sv
// Writeback stage: ALU always wins, MDU/LSU share the leftover cycles round-robin.
// One registered result per cycle feeds the register file, scoreboard and bypass.
module exe_writeback
  import exe_writeback_pkg::*;
#(
  parameter int SID_W = `SCOREBOARD_SIZE_WIDTH,
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  exe_writeback_if.slave wb_if
);
  logic             w_block;
  logic             w_alu_gnt;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [1:0]       w_rdy;
  logic             w_conflict;

  logic             r_valid;
  logic [SID_W-1:0] r_sid;
  logic [RD_W-1:0]  r_rd;
  logic [VAL_W-1:0] r_value;
  logic [CNT_W-1:0] r_cnt;

  assign w_block   = wb_if.flush_i | wb_if.alu_valid_i;
  assign w_alu_gnt = ~wb_if.flush_i & wb_if.alu_valid_i;

  assign w_req[MDU_IDX] = wb_if.mdu_valid_i;
  assign w_req[LSU_IDX] = wb_if.lsu_valid_i;

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .block (w_block),
    .gnt   (w_gnt),
    .rdy   (w_rdy)
  );

  assign wb_if.mdu_ready_o = w_rdy[MDU_IDX];
  assign wb_if.lsu_ready_o = w_rdy[LSU_IDX];

  // Counted during flush too, since a flushed requester is still being stalled.
  assign w_conflict = (w_req[MDU_IDX] & ~w_rdy[MDU_IDX]) | (w_req[LSU_IDX] & ~w_rdy[LSU_IDX]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sid   <= '0;
      r_rd    <= '0;
      r_value <= '0;
    end else begin
      r_valid <= w_alu_gnt | (|w_gnt);
      if (w_alu_gnt) begin
        r_sid   <= wb_if.alu_sid_i;
        r_rd    <= wb_if.alu_rd_i;
        r_value <= wb_if.alu_value_i;
      end else if (w_gnt[MDU_IDX]) begin
        r_sid   <= wb_if.mdu_sid_i;
        r_rd    <= wb_if.mdu_rd_i;
        r_value <= wb_if.mdu_value_i;
      end else if (w_gnt[LSU_IDX]) begin
        r_sid   <= wb_if.lsu_sid_i;
        r_rd    <= wb_if.lsu_rd_i;
        r_value <= wb_if.lsu_value_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign wb_if.wb_valid_o        = r_valid;
  assign wb_if.wb_sid_o          = r_sid;
  assign wb_if.wb_rd_o           = r_rd;
  assign wb_if.wb_value_o        = r_value;
  assign wb_if.wb_rf_we_o        = rf_write_en(r_valid, r_rd);
  assign wb_if.wb_conflict_cnt_o = r_cnt;
endmodule

// File: tb/tb_exe_writeback.sv
// Directed bench for exe_writeback with hand-computed expectations.
module tb_exe_writeback;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  exe_writeback_if #(.SID_W(4), .CNT_W(4)) bus ();

  exe_writeback #(.SID_W(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i     = 1'b0;
    bus.alu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    bus.alu_sid_i = '0; bus.alu_rd_i = '0; bus.alu_value_i = '0;
    bus.mdu_sid_i = '0; bus.mdu_rd_i = '0; bus.mdu_value_i = '0;
    bus.lsu_sid_i = '0; bus.lsu_rd_i = '0; bus.lsu_value_i = '0;

    // reset state
    #12;
    chk("rst_valid", bus.wb_valid_o, 0);
    chk("rst_we", bus.wb_rf_we_o, 0);
    chk("rst_sid", bus.wb_sid_o, 0);
    chk("rst_rd", bus.wb_rd_o, 0);
    chk("rst_value", bus.wb_value_o, 0);
    chk("rst_cnt", bus.wb_conflict_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU priority over a waiting MDU
    bus.alu_valid_i = 1'b1; bus.alu_sid_i = 4'd2; bus.alu_rd_i = 5'd5; bus.alu_value_i = 64'h1234;
    bus.mdu_valid_i = 1'b1; bus.mdu_sid_i = 4'd3; bus.mdu_rd_i = 5'd6; bus.mdu_value_i = 64'hAAAA;
    #1;
    chk("alu_mdu_rdy", bus.mdu_ready_o, 0);
    chk("alu_lsu_rdy", bus.lsu_ready_o, 0);
    tick();
    chk("alu_valid", bus.wb_valid_o, 1);
    chk("alu_sid", bus.wb_sid_o, 2);
    chk("alu_rd", bus.wb_rd_o, 5);
    chk("alu_value", bus.wb_value_o, 64'h1234);
    chk("alu_we", bus.wb_rf_we_o, 1);
    chk("alu_cnt", bus.wb_conflict_cnt_o, 1);
    bus.alu_valid_i = 1'b0;
    #1;
    chk("mdu_rdy_free", bus.mdu_ready_o, 1);
    tick();
    bus.mdu_valid_i = 1'b0;
    chk("mdu_valid", bus.wb_valid_o, 1);
    chk("mdu_sid", bus.wb_sid_o, 3);
    chk("mdu_value", bus.wb_value_o, 64'hAAAA);
    chk("mdu_cnt", bus.wb_conflict_cnt_o, 1);

    // asynchronous reset while a result is valid
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.wb_valid_o, 0);
    chk("arst_we", bus.wb_rf_we_o, 0);
    chk("arst_value", bus.wb_value_o, 0);
    chk("arst_sid", bus.wb_sid_o, 0);
    chk("arst_cnt", bus.wb_conflict_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin: both valid for 4 cycles starting from rr=0
    bus.mdu_valid_i = 1'b1; bus.mdu_sid_i = 4'd4; bus.mdu_rd_i = 5'd7; bus.mdu_value_i = 64'hA0;
    bus.lsu_valid_i = 1'b1; bus.lsu_sid_i = 4'd8; bus.lsu_rd_i = 5'd9; bus.lsu_value_i = 64'hB0;
    #1;
    chk("rr0_mdu_rdy", bus.mdu_ready_o, 1);
    chk("rr0_lsu_rdy", bus.lsu_ready_o, 0);
    tick();
    chk("rr1_value", bus.wb_value_o, 64'hA0);
    chk("rr1_sid", bus.wb_sid_o, 4);
    bus.mdu_value_i = 64'hA1; bus.mdu_sid_i = 4'd5;
    tick();
    chk("rr2_value", bus.wb_value_o, 64'hB0);
    chk("rr2_sid", bus.wb_sid_o, 8);
    bus.lsu_value_i = 64'hB1; bus.lsu_sid_i = 4'd9;
    tick();
    chk("rr3_value", bus.wb_value_o, 64'hA1);
    bus.mdu_value_i = 64'hA2;
    tick();
    chk("rr4_value", bus.wb_value_o, 64'hB1);
    chk("rr4_valid", bus.wb_valid_o, 1);
    chk("rr_cnt", bus.wb_conflict_cnt_o, 4);
    idle_inputs();

    // x0 destination
    bus.alu_valid_i = 1'b1; bus.alu_sid_i = 4'd7; bus.alu_rd_i = 5'd0; bus.alu_value_i = 64'hDEAD;
    tick();
    bus.alu_valid_i = 1'b0;
    chk("x0_valid", bus.wb_valid_o, 1);
    chk("x0_we", bus.wb_rf_we_o, 0);
    chk("x0_sid", bus.wb_sid_o, 7);
    chk("x0_value", bus.wb_value_o, 64'hDEAD);

    // MDU alone moves rr to 1, then flush must leave it there
    bus.mdu_valid_i = 1'b1; bus.mdu_sid_i = 4'd1; bus.mdu_rd_i = 5'd3; bus.mdu_value_i = 64'h55;
    tick();
    bus.mdu_valid_i = 1'b0;
    chk("solo_value", bus.wb_value_o, 64'h55);
    bus.flush_i = 1'b1;
    bus.alu_valid_i = 1'b1; bus.alu_sid_i = 4'd6; bus.alu_rd_i = 5'd2; bus.alu_value_i = 64'h77;
    bus.lsu_valid_i = 1'b1; bus.lsu_sid_i = 4'd10; bus.lsu_rd_i = 5'd11; bus.lsu_value_i = 64'hC0;
    #1;
    chk("fl_mdu_rdy", bus.mdu_ready_o, 0);
    chk("fl_lsu_rdy", bus.lsu_ready_o, 0);
    tick();
    chk("fl_valid", bus.wb_valid_o, 0);
    chk("fl_hold", bus.wb_value_o, 64'h55);
    chk("fl_cnt", bus.wb_conflict_cnt_o, 5);
    bus.flush_i = 1'b0;
    bus.alu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b1; bus.mdu_value_i = 64'hA9;
    #1;
    chk("fl_rr_mdu", bus.mdu_ready_o, 0);
    chk("fl_rr_lsu", bus.lsu_ready_o, 1);
    tick();
    chk("fl_after_value", bus.wb_value_o, 64'hC0);
    chk("fl_after_cnt", bus.wb_conflict_cnt_o, 6);
    idle_inputs();

    // counter saturation at 4 bits
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd1;
    bus.mdu_valid_i = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", bus.wb_conflict_cnt_o, 14);
    tick();
    chk("sat_15", bus.wb_conflict_cnt_o, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_20", bus.wb_conflict_cnt_o, 15);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exe_writeback.md
# exe_writeback

Single-port writeback stage directly downstream of the ALU and the other execute units. Merges results from the ALU (no backpressure), the multiply/divide unit (MDU) and the load/store unit (LSU) into one registered writeback port. That port drives the register-file write, scoreboard completion, and the operand bypass network. ALU results are never stalled; MDU and LSU compete round-robin for the cycles the ALU leaves free.

## Interface
- `SID_W`, default `` `SCOREBOARD_SIZE_WIDTH ``: scoreboard id width.
- `CNT_W`, default 32: width of the conflict counter.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `alu_valid_i` in 1: ALU result valid; no ready, must always be accepted.
- `alu_sid_i` in SID_W: ALU scoreboard id.
- `alu_rd_i` in 5: ALU destination register.
- `alu_value_i` in 64: ALU result.
- `mdu_valid_i` in 1 / `mdu_ready_o` out 1: MDU handshake.
- `mdu_sid_i` in SID_W, `mdu_rd_i` in 5, `mdu_value_i` in 64: MDU payload.
- `lsu_valid_i` in 1 / `lsu_ready_o` out 1: LSU handshake.
- `lsu_sid_i` in SID_W, `lsu_rd_i` in 5, `lsu_value_i` in 64: LSU payload.
- `wb_valid_o` out 1: writeback valid; this is the scoreboard completion strobe.
- `wb_sid_o` out SID_W, `wb_rd_o` out 5, `wb_value_o` out 64: writeback payload.
- `wb_rf_we_o` out 1: register-file write enable, equal to `wb_valid_o & (wb_rd_o != 0)`.
- `wb_conflict_cnt_o` out CNT_W: saturating count of cycles in which a valid MDU/LSU request was not granted.

## Operation
- **Grant priority, evaluated each cycle:**
  1. `flush_i` set: no grant.
  2. Otherwise, `alu_valid_i` set: ALU wins.
  3. Otherwise, if exactly one of MDU/LSU is valid: that source wins.
  4. Otherwise, if both are valid: the round-robin pointer `rr` selects. `rr=0` means MDU is preferred; `rr=1` means LSU is preferred.
- **Ready outputs:**
  - `mdu_ready_o = ~flush_i & ~alu_valid_i & (~lsu_valid_i | ~rr)`.
  - `lsu_ready_o = ~flush_i & ~alu_valid_i & (~mdu_valid_i | rr)`.
  - Ready is asserted regardless of that source's own valid. A transfer occurs when valid & ready.
- **Round-robin pointer:**
  - After an MDU transfer, `rr` becomes 1. After an LSU transfer, `rr` becomes 0.
  - An ALU grant, or a cycle with no grant, leaves `rr` unchanged.
- **Output register:**
  - Loaded with the granted payload when a grant occurs, and `wb_valid_o` becomes 1.
  - Otherwise `wb_valid_o` becomes 0. The payload holds its last value.
- **Flush:** `flush_i` clears `wb_valid_o` on the next edge and grants nothing in that cycle. Upstream units keep valid/payload asserted across a stall; what they do with their own state on flush is their responsibility.
- **x0 handling:** `rd == 0` still completes the scoreboard (`wb_valid_o = 1`) but `wb_rf_we_o = 0`.
- **Conflict counter:**
  - Increments by 1 in each cycle where `(mdu_valid_i & ~mdu_ready_o) | (lsu_valid_i & ~lsu_ready_o)`, including flush cycles.
  - Saturates at all-ones and does not wrap.
- **Upstream rule:** MDU/LSU hold valid and payload stable until the transfer completes. The bench checks this, not the RTL.

## Timing
- Latency: 1 cycle from transfer to `wb_*` outputs.
- `mdu_ready_o` and `lsu_ready_o` are combinational from `flush_i`, `alu_valid_i`, the valids and `rr`. There is no combinational path from any payload input to any output.
- **Reset values:**
  - `wb_valid_o`, `wb_rf_we_o`: 0.
  - `wb_sid_o`, `wb_rd_o`, `wb_value_o`: 0.
  - `wb_conflict_cnt_o`: 0.
  - `rr`: 0.
  - Ready outputs are combinational and evaluate normally during reset; downstream ignores them while `rst_n` is low.
- Reset asserted mid-operation clears all state asynchronously. Any in-flight granted result is lost.
- Throughput: 1 result per cycle. With ALU results back-to-back, MDU/LSU wait indefinitely; this is accepted, and the stall is visible in the conflict counter.

## Structure
- No new package types. `SCOREBOARD_SIZE_WIDTH` comes from the shared defines file.
- One sub-module, `wb_rr_arb2`: a 2-requester round-robin arbiter holding `rr`, with inputs `req[1:0]` and `block`, and outputs `gnt[1:0]`.
- The output register, ALU priority mux and conflict counter live in `exe_writeback`.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with `wb_valid_o=1`. All outputs go to 0 immediately, and `rr=0` after release.
- **ALU priority:** `alu_valid_i=1` (sid=2, rd=5, value=0x1234) together with `mdu_valid_i=1`. Next cycle the `wb_*` outputs show the ALU payload, `mdu_ready_o` was 0, and the counter is 1. The following cycle, with ALU idle, the MDU result is written.
- **Round-robin:** MDU and LSU both valid for 4 cycles with the ALU idle. Grants go MDU, LSU, MDU, LSU, and `wb_value_o` alternates accordingly.
- **x0 write:** ALU result with rd=0, value=0xDEAD. Then `wb_valid_o=1`, `wb_rf_we_o=0`, and `wb_sid_o` matches.
- **Flush:** `flush_i=1` with ALU and LSU valid. Next cycle `wb_valid_o=0`, both readies were 0, and `rr` is unchanged.
- **Counter saturation:** with `CNT_W=4`, hold the ALU and MDU valid for 20 cycles. The counter reaches 15 and stays at 15.
